// File: rtl/hog_out_pio.sv
// Purpose   : Avalon-MM output port driving a 32-bit word from the HPS to the HOG pipeline.
// Latency   : register writes take effect on the next clk edge; readdata is registered (1 cycle).
// Backpress : with HS_EN=1 a word is held on out_port until out_valid & out_ready; later writes drop.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   address, chipselect  Avalon-MM word address and slave select
//   write_n, writedata   active-low write strobe and write data
//   readdata             registered read data (updated every clock from address)
//   out_port             output word to the fabric
//   out_valid, out_ready valid/ready handshake towards the HOG pipeline
//   irq                  level interrupt, IRQ_EN & DONE (registered)
//
// Register map (word addresses):
//   0 DATA     R/W  reads return out_port
//   1 STATUS   bit0 PENDING (RO), bit1 OVERRUN (W1C), bit2 DONE (W1C)
//   2 CONTROL  R/W  bit0 HS_EN, bit1 IRQ_EN
//   4 OUTSET   WO   out_port | writedata
//   5 OUTCLEAR WO   out_port & ~writedata
//   3, 6, 7         read 0, writes ignored

module hog_out_pio #(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  irq
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_STATUS   = 3'd1;
   localparam logic [2:0] ADDR_CONTROL  = 3'd2;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                  state_q,    state_d;
   logic [DATA_WIDTH-1:0]   out_port_q, out_port_d;
   logic                    done_q,     done_d;
   logic                    overrun_q,  overrun_d;
   logic                    hs_en_q,    hs_en_d;
   logic                    irq_en_q,   irq_en_d;
   logic                    irq_q,      irq_d;
   logic [31:0]             readdata_q, readdata_d;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic                    wr;
   logic                    data_wr;
   logic                    status_wr;
   logic                    control_wr;
   logic [DATA_WIDTH-1:0]   wdata_trunc;
   logic [DATA_WIDTH-1:0]   next_word;
   logic                    done_set;
   logic                    overrun_set;

   assign wr          = chipselect & ~write_n;
   assign data_wr     = wr & ((address == ADDR_DATA) ||
                              (address == ADDR_OUTSET) ||
                              (address == ADDR_OUTCLEAR));
   assign status_wr   = wr & (address == ADDR_STATUS);
   assign control_wr  = wr & (address == ADDR_CONTROL);
   assign wdata_trunc = writedata[DATA_WIDTH-1:0];

   // Candidate value for out_port from whichever data register is written.
   always_comb begin
      next_word = wdata_trunc;
      case (address)
         ADDR_OUTSET:   next_word = out_port_q | wdata_trunc;
         ADDR_OUTCLEAR: next_word = out_port_q & ~wdata_trunc;
         default:       next_word = wdata_trunc;
      endcase
   end

   // ------------------------------------------------------------------
   // Control register
   // ------------------------------------------------------------------
   always_comb begin
      hs_en_d  = hs_en_q;
      irq_en_d = irq_en_q;
      if (control_wr) begin
         hs_en_d  = writedata[0];
         irq_en_d = writedata[1];
      end
   end

   // ------------------------------------------------------------------
   // Handshake FSM and out_port
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         out_port_q <= RESET_VALUE;
      end else begin
         state_q    <= state_d;
         out_port_q <= out_port_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      out_port_d  = out_port_q;
      done_set    = 1'b0;
      overrun_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // In direct mode the FSM never leaves IDLE, so this also covers HS_EN=0.
            if (data_wr) begin
               out_port_d = next_word;
               if (hs_en_q) begin
                  state_d = ST_PENDING;
               end
            end
         end
         ST_PENDING: begin
            if (out_ready) begin
               done_set = 1'b1;
               // A write coinciding with acceptance becomes the next pending word.
               if (data_wr) begin
                  out_port_d = next_word;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (data_wr) begin
               // Word still owned by the fabric: drop the write, flag it.
               overrun_set = 1'b1;
            end
            // Turning off the handshake abandons the pending word but keeps out_port.
            if (!hs_en_d) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Sticky status bits: a set event in the same cycle as W1C wins.
   // ------------------------------------------------------------------
   always_comb begin
      done_d    = done_q;
      overrun_d = overrun_q;
      if (status_wr && writedata[2]) begin
         done_d = 1'b0;
      end
      if (status_wr && writedata[1]) begin
         overrun_d = 1'b0;
      end
      if (done_set) begin
         done_d = 1'b1;
      end
      if (overrun_set) begin
         overrun_d = 1'b1;
      end
   end

   // irq follows the registered status/control, so it trails them by one cycle.
   assign irq_d = irq_en_q & done_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         hs_en_q   <= 1'b0;
         irq_en_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         done_q    <= done_d;
         overrun_q <= overrun_d;
         hs_en_q   <= hs_en_d;
         irq_en_q  <= irq_en_d;
         irq_q     <= irq_d;
      end
   end

   // ------------------------------------------------------------------
   // Read path: sampled every clock from address, chipselect ignored.
   // ------------------------------------------------------------------
   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:    readdata_d[DATA_WIDTH-1:0] = out_port_q;
         ADDR_STATUS:  readdata_d[2:0] = {done_q, overrun_q, (state_q == ST_PENDING)};
         ADDR_CONTROL: readdata_d[1:0] = {irq_en_q, hs_en_q};
         default:      readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q <= '0;
      end else begin
         readdata_q <= readdata_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign readdata  = readdata_q;
   assign out_port  = out_port_q;
   assign out_valid = (state_q == ST_PENDING);
   assign irq       = irq_q;

endmodule

// File: tb/tb_hog_out_pio.sv
// Purpose   : directed self-checking bench for hog_out_pio (32-bit and 8-bit instances).
// Latency   : inputs driven at the falling edge, outputs sampled at the following falling edge.
// Backpress : out_ready is driven directly from the stimulus sequence.

module tb_hog_out_pio;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic        out_ready;

   logic [31:0] readdata;
   logic [31:0] out_port;
   logic        out_valid;
   logic        irq;

   logic [31:0] readdata8;
   logic [7:0]  out_port8;
   logic        out_valid8;
   logic        irq8;

   int n_chk  = 0;
   int n_pass = 0;

   hog_out_pio #(.DATA_WIDTH(32), .RESET_VALUE(32'h0)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .irq        (irq)
   );

   hog_out_pio #(.DATA_WIDTH(8), .RESET_VALUE(8'h3C)) u_dut8 (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata8),
      .out_port   (out_port8),
      .out_valid  (out_valid8),
      .out_ready  (out_ready),
      .irq        (irq8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One bus write; returns at the falling edge after the write edge.
   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   // Presents an address for one edge; readdata is valid on return.
   task automatic bus_rd(input logic [2:0] a);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      @(negedge clk);
      chipselect = 1'b0;
   endtask

   initial begin
      int vcnt;
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 3'd0;
      writedata  = '0;
      out_ready  = 1'b0;

      // Reset state
      #12;
      chk("rst_readdata",  readdata,             32'h0);
      chk("rst_out_port",  out_port,             32'h0);
      chk("rst_out_port8", {24'h0, out_port8},   32'h3C);
      chk("rst_out_valid", {31'h0, out_valid},   32'h0);
      chk("rst_irq",       {31'h0, irq},         32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      bus_rd(3'd0);
      chk("rd_data_rst",   readdata,  32'h0);
      chk("rd_data8_rst",  readdata8, 32'h3C);
      bus_rd(3'd1);
      chk("rd_status_rst", readdata,  32'h0);
      chk("valid_rst",     {31'h0, out_valid}, 32'h0);
      chk("irq_rst",       {31'h0, irq},       32'h0);

      // Truncation to DATA_WIDTH
      bus_wr(3'd0, 32'h0000_01FF);
      chk("trunc_out8",  {24'h0, out_port8}, 32'hFF);
      chk("trunc_out32", out_port,           32'h1FF);
      bus_rd(3'd0);
      chk("trunc_rd8",   readdata8, 32'h0000_00FF);

      // Direct mode: DATA, OUTSET, OUTCLEAR; out_ready high must not matter
      out_ready = 1'b1;
      bus_wr(3'd0, 32'h0000_00F0);
      chk("direct_data",   out_port, 32'hF0);
      chk("direct_valid0", {31'h0, out_valid}, 32'h0);
      bus_wr(3'd4, 32'h0000_000F);
      chk("direct_set",    out_port, 32'hFF);
      bus_wr(3'd5, 32'h0000_0030);
      chk("direct_clr",    out_port, 32'hCF);
      chk("direct_valid1", {31'h0, out_valid}, 32'h0);
      out_ready = 1'b0;
      bus_rd(3'd1);
      chk("direct_status", readdata, 32'h0);

      // Unmapped addresses
      bus_wr(3'd3, 32'hFFFF_FFFF);
      chk("unmapped_wr_port", out_port, 32'hCF);
      bus_rd(3'd3);
      chk("rd_addr3", readdata, 32'h0);
      bus_rd(3'd6);
      chk("rd_addr6", readdata, 32'h0);
      bus_rd(3'd7);
      chk("rd_addr7", readdata, 32'h0);
      bus_rd(3'd4);
      chk("rd_outset", readdata, 32'h0);

      // Handshake mode: 5 cycles not ready, then 1 cycle ready
      bus_wr(3'd2, 32'hFFFF_FFFF);
      bus_rd(3'd2);
      chk("rd_control", readdata, 32'h3);
      chk("hs_en_keeps_port", out_port, 32'hCF);
      bus_wr(3'd0, 32'hA5A5_0001);
      chk("hs_load", out_port, 32'hA5A5_0001);
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) vcnt++;
         out_ready = (i == 5);
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("hs_valid_cycles", vcnt, 6);
      bus_rd(3'd1);
      chk("hs_status_done", readdata, 32'h4);
      chk("hs_irq_on", {31'h0, irq}, 32'h1);
      bus_wr(3'd1, 32'h0000_0004);
      chk("irq_lag", {31'h0, irq}, 32'h1);
      @(negedge clk);
      chk("irq_off", {31'h0, irq}, 32'h0);

      // Overrun: write while pending and not accepted
      bus_wr(3'd0, 32'h11);
      chk("pend_valid", {31'h0, out_valid}, 32'h1);
      bus_wr(3'd0, 32'h22);
      chk("overrun_port", out_port, 32'h11);
      bus_rd(3'd1);
      chk("overrun_status", readdata, 32'h3);

      // Write in the same cycle as acceptance
      out_ready = 1'b1;
      bus_wr(3'd0, 32'h33);
      out_ready = 1'b0;
      chk("acc_wr_port",  out_port, 32'h33);
      chk("acc_wr_valid", {31'h0, out_valid}, 32'h1);
      bus_rd(3'd1);
      chk("acc_wr_status", readdata, 32'h7);

      // DONE W1C racing a DONE set: set wins
      out_ready = 1'b1;
      bus_wr(3'd1, 32'h0000_0004);
      out_ready = 1'b0;
      bus_rd(3'd1);
      chk("w1c_race_status", readdata, 32'h6);

      // Clearing HS_EN while pending
      bus_wr(3'd1, 32'h0000_0006);
      bus_rd(3'd1);
      chk("w1c_both", readdata, 32'h0);
      bus_wr(3'd0, 32'h44);
      bus_wr(3'd2, 32'h0000_0002);
      chk("hs_off_valid", {31'h0, out_valid}, 32'h0);
      chk("hs_off_port",  out_port, 32'h44);
      bus_rd(3'd1);
      chk("hs_off_status", readdata, 32'h0);

      // Asynchronous reset with a word pending
      bus_wr(3'd2, 32'h0000_0003);
      bus_wr(3'd0, 32'h55);
      chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", {31'h0, out_valid}, 32'h0);
      chk("arst_port",  out_port, 32'h0);
      chk("arst_port8", {24'h0, out_port8}, 32'h3C);
      @(negedge clk);
      reset_n = 1'b1;
      bus_rd(3'd1);
      chk("post_rst_status", readdata, 32'h0);
      bus_rd(3'd2);
      chk("post_rst_control", readdata, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
